mem_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, between EX and WB. Issues data-bus load/store transactions through a request/acknowledge handshake, stalls the pipeline while a transaction is outstanding, and extracts and extends load data. Registers the MEM/WB boundary and drives the `oper`, `rd_regf`, `rd_data_a`, `rd_data_b` and `pc` values consumed by the writeback stage. Non-memory instructions pass through in one cycle.

---
 rtl/mem_pkg.sv | 67 ++++++
 rtl/mem_align.sv | 73 +++++++
 rtl/mem_access.sv | 181 ++++++++++++++++++
 tb/tb_mem_access.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the MEM stage.
// Build option: MEM_ALIGN_CHECK_EN (consumed by mem_align) enables address-alignment exceptions.
package mem_pkg;

  localparam int W_OPER = 6;
  localparam int W_REGF = 5;
  localparam int W_DATA = 32;
  localparam int W_ADDR = 32;
  localparam int W_TCNT = 16;

  // Operation codes; memory ops reuse the MIPS primary opcode values
  localparam logic [W_OPER-1:0] OP_NOP  = 6'h00;
  localparam logic [W_OPER-1:0] OP_ADDU = 6'h01;
  localparam logic [W_OPER-1:0] OP_SUBU = 6'h02;
  localparam logic [W_OPER-1:0] OP_AND  = 6'h03;
  localparam logic [W_OPER-1:0] OP_OR   = 6'h04;
  localparam logic [W_OPER-1:0] OP_LB   = 6'h20;
  localparam logic [W_OPER-1:0] OP_LH   = 6'h21;
  localparam logic [W_OPER-1:0] OP_LW   = 6'h23;
  localparam logic [W_OPER-1:0] OP_LBU  = 6'h24;
  localparam logic [W_OPER-1:0] OP_LHU  = 6'h25;
  localparam logic [W_OPER-1:0] OP_SB   = 6'h28;
  localparam logic [W_OPER-1:0] OP_SH   = 6'h29;
  localparam logic [W_OPER-1:0] OP_SW   = 6'h2B;

  // Byte-enable base patterns, shifted into place by the byte offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {IDLE, REQ} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // One MEM/WB boundary entry
  typedef struct packed {
    logic              valid;
    logic [W_OPER-1:0] oper;
    logic [W_REGF-1:0] rd;
    logic [W_DATA-1:0] data_a;
    logic [W_DATA-1:0] data_b;
    logic [W_ADDR-1:0] pc;
    logic              adel;
    logic              ades;
    logic              bus;
  } wb_t;

  function automatic logic is_load(input logic [W_OPER-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [W_OPER-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic size_t acc_size(input logic [W_OPER-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic logic ld_signed(input logic [W_OPER-1:0] op);
    return op inside {OP_LB, OP_LH};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store replication / byte enables, load
// extraction / extension, and misalignment detection.
// Build option: MEM_ALIGN_CHECK_EN enables misalignment detection; otherwise misalign = 0.
module mem_align
  import mem_pkg::*;
(
  input  logic [W_OPER-1:0] acc_oper,
  input  logic [1:0]        acc_off,
  input  logic [W_DATA-1:0] store_data,
  output logic [3:0]        be,
  output logic [W_DATA-1:0] wdata,
  output logic              misalign,
  input  logic [W_OPER-1:0] ld_oper,
  input  logic [1:0]        ld_off,
  input  logic [W_DATA-1:0] rdata,
  output logic [W_DATA-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the datum across lanes, enable only the target lanes
  always_comb begin
    be    = BE_WORD;
    wdata = store_data;
    if (is_store(acc_oper)) begin
      case (acc_size(acc_oper))
        SZ_B: begin
          be    = BE_BYTE << acc_off;
          wdata = {4{store_data[7:0]}};
        end
        SZ_H: begin
          be    = BE_HALF << {acc_off[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = BE_WORD;
          wdata = store_data;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0
  always_comb begin
    misalign = 1'b0;
    if (is_load(acc_oper) || is_store(acc_oper)) begin
      case (acc_size(acc_oper))
        SZ_H:    misalign = acc_off[0];
        SZ_W:    misalign = (acc_off != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Load side: little-endian lane pick, then sign or zero extend
  always_comb begin
    ld_byte = rdata[8*ld_off +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (acc_size(ld_oper))
      SZ_B:    ld_data = ld_signed(ld_oper) ? {{24{ld_byte[7]}}, ld_byte}
                                            : {24'b0, ld_byte};
      SZ_H:    ld_data = ld_signed(ld_oper) ? {{16{ld_half[15]}}, ld_half}
                                            : {16'b0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the five-stage MIPS pipeline: data-bus handshake, stall
// generation, load extraction and the MEM/WB register.
// Build option: MEM_ALIGN_CHECK_EN turns misaligned accesses into exc_adel/exc_ades
// without a bus request.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W_OPER-1:0] oper_i,
  input  logic [W_REGF-1:0] rd_regf_i,
  input  logic [W_DATA-1:0] rd_data_a_i,
  input  logic [W_DATA-1:0] store_data_i,
  input  logic [W_ADDR-1:0] pc_i,
  output logic              stall,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [3:0]        dbus_be,
  output logic [W_ADDR-1:0] dbus_addr,
  output logic [W_DATA-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [W_DATA-1:0] dbus_rdata,
  output logic              wb_valid,
  output logic [W_OPER-1:0] oper_o,
  output logic [W_REGF-1:0] rd_regf_o,
  output logic [W_DATA-1:0] rd_data_a_o,
  output logic [W_DATA-1:0] rd_data_b_o,
  output logic [W_ADDR-1:0] pc_o,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_bus
);

  localparam logic [W_TCNT-1:0] TMO_LAST =
    W_TCNT'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);
  localparam logic TMO_EN = (BUS_TIMEOUT != 0);

  state_t            state;
  logic [W_TCNT-1:0] tcnt;

  // Transaction context held for the whole REQ phase
  logic [W_OPER-1:0] h_oper;
  logic [W_REGF-1:0] h_rd;
  logic [W_DATA-1:0] h_addr;
  logic [W_ADDR-1:0] h_pc;

  // wb is the MEM/WB register; pend holds a one-cycle result that collided
  // with a bus completion on the ack cycle, so program order is kept
  wb_t wb, pend, imm_res, cmp_res;

  logic              accept, in_mem, mis, go_bus, imm;
  logic              ack_done, tmo, cmp;
  logic [3:0]        be_n;
  logic [W_DATA-1:0] wdata_n, ld_data;

  mem_align u_align (
    .acc_oper   (oper_i),
    .acc_off    (rd_data_a_i[1:0]),
    .store_data (store_data_i),
    .be         (be_n),
    .wdata      (wdata_n),
    .misalign   (mis),
    .ld_oper    (h_oper),
    .ld_off     (h_addr[1:0]),
    .rdata      (dbus_rdata),
    .ld_data    (ld_data)
  );

  assign stall    = (state == REQ) && !dbus_ack;
  assign accept   = in_valid && !stall;
  assign in_mem   = is_load(oper_i) || is_store(oper_i);
  assign go_bus   = accept && in_mem && !mis;
  assign imm      = accept && (!in_mem || mis);
  assign ack_done = (state == REQ) && dbus_ack;
  assign tmo      = TMO_EN && (state == REQ) && !dbus_ack && (tcnt == TMO_LAST);
  assign cmp      = ack_done || tmo;

  // Result of an instruction that finishes without the bus
  always_comb begin
    imm_res        = '0;
    imm_res.valid  = 1'b1;
    imm_res.oper   = oper_i;
    imm_res.rd     = in_mem ? '0 : rd_regf_i;
    imm_res.data_a = rd_data_a_i;
    imm_res.pc     = pc_i;
    imm_res.adel   = mis && is_load(oper_i);
    imm_res.ades   = mis && is_store(oper_i);
  end

  // Result of a bus transaction that completes (ack) or aborts (timeout)
  always_comb begin
    cmp_res        = '0;
    cmp_res.valid  = 1'b1;
    cmp_res.oper   = h_oper;
    cmp_res.rd     = (ack_done && is_load(h_oper)) ? h_rd : '0;
    cmp_res.data_a = h_addr;
    cmp_res.data_b = (ack_done && is_load(h_oper)) ? ld_data : '0;
    cmp_res.pc     = h_pc;
    cmp_res.bus    = tmo;
  end

  // Bus FSM with registered request outputs and held transaction context
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_be    <= '0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      h_oper     <= '0;
      h_rd       <= '0;
      h_addr     <= '0;
      h_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_bus) state <= REQ;
        end
        REQ: begin
          if (cmp && !go_bus) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (go_bus) begin
        tcnt       <= '0;
        dbus_req   <= 1'b1;
        dbus_we    <= is_store(oper_i);
        dbus_be    <= be_n;
        dbus_addr  <= {rd_data_a_i[W_DATA-1:2], 2'b00};
        dbus_wdata <= is_store(oper_i) ? wdata_n : '0;
        h_oper     <= oper_i;
        h_rd       <= rd_regf_i;
        h_addr     <= rd_data_a_i;
        h_pc       <= pc_i;
      end else if (cmp) begin
        tcnt       <= '0;
        dbus_req   <= 1'b0;
        dbus_we    <= 1'b0;
        dbus_be    <= '0;
        dbus_addr  <= '0;
        dbus_wdata <= '0;
      end else if (state == REQ) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // MEM/WB register: completion first, then any parked result, then new work
  always_ff @(posedge clk) begin
    if (rst) begin
      wb   <= '0;
      pend <= '0;
    end else if (cmp) begin
      wb   <= cmp_res;
      pend <= imm ? imm_res : '0;
    end else if (pend.valid) begin
      wb   <= pend;
      pend <= imm ? imm_res : '0;
    end else begin
      wb   <= imm ? imm_res : '0;
      pend <= '0;
    end
  end

  assign wb_valid    = wb.valid;
  assign oper_o      = wb.oper;
  assign rd_regf_o   = wb.rd;
  assign rd_data_a_o = wb.data_a;
  assign rd_data_b_o = wb.data_b;
  assign pc_o        = wb.pc;
  assign exc_adel    = wb.adel;
  assign exc_ades    = wb.ades;
  assign exc_bus     = wb.bus;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with hand-computed expectations.
// Build option: MEM_ALIGN_CHECK_EN selects the aligned-check expectations for the LW@3001 case.
module tb_mem_access;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [W_OPER-1:0] oper_i;
  logic [W_REGF-1:0] rd_regf_i;
  logic [W_DATA-1:0] rd_data_a_i, store_data_i;
  logic [W_ADDR-1:0] pc_i;
  logic              stall, dbus_req, dbus_we, dbus_ack;
  logic [3:0]        dbus_be;
  logic [W_ADDR-1:0] dbus_addr, pc_o;
  logic [W_DATA-1:0] dbus_wdata, dbus_rdata, rd_data_a_o, rd_data_b_o;
  logic              wb_valid, exc_adel, exc_ades, exc_bus;
  logic [W_OPER-1:0] oper_o;
  logic [W_REGF-1:0] rd_regf_o;

  int n_run  = 0;
  int n_fail = 0;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .oper_i(oper_i),
    .rd_regf_i(rd_regf_i), .rd_data_a_i(rd_data_a_i), .store_data_i(store_data_i),
    .pc_i(pc_i), .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_be(dbus_be), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
    .oper_o(oper_o), .rd_regf_o(rd_regf_o), .rd_data_a_o(rd_data_a_o),
    .rd_data_b_o(rd_data_b_o), .pc_o(pc_o), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W_OPER-1:0] op, input logic [W_REGF-1:0] rd,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc);
    in_valid = 1'b1; oper_i = op; rd_regf_i = rd;
    rd_data_a_i = a; store_data_i = sd; pc_i = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_cnt, req_cnt;
    rst = 1'b1; in_valid = 1'b0; oper_i = OP_NOP; rd_regf_i = '0;
    rd_data_a_i = '0; store_data_i = '0; pc_i = '0;
    dbus_ack = 1'b0; dbus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd", 32'(rd_regf_o), 32'd0);

    // ADDU passes through in one cycle
    issue(OP_ADDU, 5'd5, 32'h1234, 32'h0, 32'h100);
    tick(); in_valid = 1'b0;
    chk("addu_valid", 32'(wb_valid), 32'd1);
    chk("addu_rd", 32'(rd_regf_o), 32'd5);
    chk("addu_a", rd_data_a_o, 32'h1234);
    chk("addu_b", rd_data_b_o, 32'h0);
    chk("addu_pc", pc_o, 32'h100);
    chk("addu_req", 32'(dbus_req), 32'd0);
    tick();
    chk("bubble_valid", 32'(wb_valid), 32'd0);

    // LB at 0x1003: three stalled REQ cycles, ack in the fourth
    issue(OP_LB, 5'd7, 32'h1003, 32'h0, 32'h104);
    tick(); in_valid = 1'b0;
    chk("lb_req", 32'(dbus_req), 32'd1);
    chk("lb_addr", dbus_addr, 32'h1000);
    chk("lb_we", 32'(dbus_we), 32'd0);
    chk("lb_be", 32'(dbus_be), 32'hF);
    stall_cnt = 0;
    dbus_rdata = 32'h80FF_0000;
    for (int k = 1; k <= 4; k++) begin
      dbus_ack = (k == 4);
      #1;
      if (stall) stall_cnt++;
      tick();
    end
    dbus_ack = 1'b0;
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lb_valid", 32'(wb_valid), 32'd1);
    chk("lb_rd", 32'(rd_regf_o), 32'd7);
    chk("lb_b", rd_data_b_o, 32'hFFFF_FF80);
    chk("lb_a", rd_data_a_o, 32'h1003);
    chk("lb_req_drop", 32'(dbus_req), 32'd0);

    // LBU same address, minimum latency
    issue(OP_LBU, 5'd8, 32'h1003, 32'h0, 32'h108);
    tick(); in_valid = 1'b0;
    chk("lbu_pending", 32'(wb_valid), 32'd0);
    dbus_ack = 1'b1;
    tick(); dbus_ack = 1'b0;
    chk("lbu_valid", 32'(wb_valid), 32'd1);
    chk("lbu_b", rd_data_b_o, 32'h0000_0080);

    // SH at 0x2002
    issue(OP_SH, 5'd9, 32'h2002, 32'hAAAA_BEEF, 32'h10C);
    tick(); in_valid = 1'b0;
    chk("sh_we", 32'(dbus_we), 32'd1);
    chk("sh_be", 32'(dbus_be), 32'hC);
    chk("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dbus_addr, 32'h2000);
    dbus_ack = 1'b1;
    tick(); dbus_ack = 1'b0;
    chk("sh_valid", 32'(wb_valid), 32'd1);
    chk("sh_rd", 32'(rd_regf_o), 32'd0);

    // LW at 0x3001
    issue(OP_LW, 5'd10, 32'h3001, 32'h0, 32'h110);
    tick(); in_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("lwmis_req", 32'(dbus_req), 32'd0);
    chk("lwmis_valid", 32'(wb_valid), 32'd1);
    chk("lwmis_adel", 32'(exc_adel), 32'd1);
    chk("lwmis_rd", 32'(rd_regf_o), 32'd0);
`else
    chk("lw_req", 32'(dbus_req), 32'd1);
    chk("lw_addr", dbus_addr, 32'h3000);
    dbus_rdata = 32'hDEAD_BEEF; dbus_ack = 1'b1;
    tick(); dbus_ack = 1'b0;
    chk("lw_b", rd_data_b_o, 32'hDEAD_BEEF);
    chk("lw_rd", 32'(rd_regf_o), 32'd10);
`endif
    tick();

    // SW with no ack: timeout after 4 REQ cycles
    issue(OP_SW, 5'd11, 32'h4000, 32'h1111_2222, 32'h114);
    tick(); in_valid = 1'b0;
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (dbus_req) req_cnt++;
      if (i == 4) begin
        chk("tmo_exc_bus", 32'(exc_bus), 32'd1);
        chk("tmo_stall", 32'(stall), 32'd0);
        chk("tmo_valid", 32'(wb_valid), 32'd1);
        chk("tmo_rd", 32'(rd_regf_o), 32'd0);
      end
      tick();
    end
    chk("tmo_req_cycles", 32'(req_cnt), 32'd4);

    // Reset in the 2nd REQ cycle, late ack afterwards
    issue(OP_LW, 5'd12, 32'h5000, 32'h0, 32'h118);
    tick(); in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
    #1;
    chk("rstreq_req", 32'(dbus_req), 32'd0);
    chk("rstreq_valid", 32'(wb_valid), 32'd0);
    chk("rstreq_stall", 32'(stall), 32'd0);
    tick(); dbus_ack = 1'b0;
    chk("lateack_valid", 32'(wb_valid), 32'd0);
    chk("lateack_b", rd_data_b_o, 32'h0);

    // Back-to-back: ADDU accepted on the LW ack cycle, retires right after
    issue(OP_LW, 5'd3, 32'h6000, 32'h0, 32'h11C);
    tick();
    issue(OP_ADDU, 5'd4, 32'h55, 32'h0, 32'h120);
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_0001;
    #1;
    chk("b2b_stall", 32'(stall), 32'd0);
    tick(); in_valid = 1'b0; dbus_ack = 1'b0;
    chk("b2b_lw_rd", 32'(rd_regf_o), 32'd3);
    chk("b2b_lw_b", rd_data_b_o, 32'hCAFE_0001);
    tick();
    chk("b2b_addu_valid", 32'(wb_valid), 32'd1);
    chk("b2b_addu_rd", 32'(rd_regf_o), 32'd4);
    chk("b2b_addu_a", rd_data_a_o, 32'h55);
    tick();
    chk("b2b_bubble", 32'(wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
